apb4_req_arbiter: RTL
=====================

// Module: apb4_req_arbiter
// PURPOSE
//  Shares one APB4 master port between NREQ local requesters. Each requester presents a simple req/ack command.
//  Round-robin arbitration picks one request. The block runs the APB4 SETUP/ACCESS sequence on the bus and
//  returns read data and error to the winner. It sits between internal engines and the APB4 slave fabric.
// PARAMETERS
//  NREQ        2    number of requesters (2..8)
//  ADDRWIDTH   12   APB4 address width
//  TIMEOUT_CYC 255  max ACCESS cycles with pready=0 before forced abort (used only with APB4_TIMEOUT_EN)
// PORTS
//  pclk      in   1              clock; one clock domain
//  preset    in   1              reset, synchronous, active-high
//  req       in   NREQ           request per requester; held with command fields until its req_ack
//  req_addr  in   NREQ*ADDRWIDTH per-requester address, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
//  req_write in   NREQ           1=write 0=read
//  req_wdata in   NREQ*32        write data, requester i at [i*32 +: 32]
//  req_strb  in   NREQ*4         byte strobes, requester i at [i*4 +: 4]
//  req_ack   out  NREQ           one-cycle completion pulse, one-hot
//  req_rdata out  32             read data, valid while req_ack is high
//  req_err   out  1              pslverr (or timeout) of the completed transfer, valid with req_ack
//  busy      out  1              high in SETUP/ACCESS
//  psel      out  1              APB4 select
//  paddr     out  ADDRWIDTH      APB4 address
//  penable   out  1              APB4 enable
//  pwrite    out  1              APB4 direction
//  pwdata    out  32             APB4 write data
//  pstrb     out  4              APB4 strobes; forced 4'b0000 on reads
//  prdata    in   32             APB4 read data
//  pready    in   1              APB4 ready
//  pslverr   in   1              APB4 error
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is synchronous and active-high. While preset=1 at a pclk edge, every
//    output goes to 0: psel, penable, paddr, pwrite, pwdata, pstrb, req_ack, req_rdata, req_err and busy.
//    FSM=IDLE. The round-robin pointer is set to NREQ-1, so requester 0 has top priority first.
//  - Reset mid-transfer: the bus is dropped on the next edge. No req_ack is issued for the abandoned transfer.
//  - FSM IDLE: if any eligible req, grant the first set bit searching from ptr+1 modulo NREQ and set ptr=grant.
//    On the same edge, register the winner's addr, write, wdata and strb (strb&{4{write}}) onto the bus.
//    psel=1, penable=0, next state SETUP.
//  - Eligibility: a requester whose req_ack is high in the current cycle is masked from arbitration.
//  - FSM SETUP: one cycle exactly, then ACCESS with penable=1.
//  - FSM ACCESS: stay while pready=0; bus fields are held stable.
//    On pready=1: psel=0, penable=0, next IDLE. Next cycle: req_ack[grant]=1, req_rdata=prdata (0 on writes),
//    req_err=pslverr.
//  - Latency: req seen in IDLE at cycle 0 -> SETUP at 1 -> ACCESS at 2 -> req_ack at 3 (pready=1 at 2).
//  - Throughput: peak one transfer per 3 cycles; psel deasserts for at least one cycle between transfers.
//  - Fairness: with all requesters always pending, grants rotate 0,1,..,NREQ-1,0.
//  - A req that drops before grant is ignored. Dropping req after grant is illegal and does not abort the transfer.
//  - req_rdata and req_err hold their last value after req_ack falls. busy = (state!=IDLE).
// CONFIGURATION
//  APB4_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
//    When the count reaches TIMEOUT_CYC and pready is still 0, the transfer is forced to complete.
//    psel/penable drop and the FSM returns to IDLE. req_ack pulses with req_err=1 and req_rdata=0.
//    If pready=1 in the same cycle the count reaches TIMEOUT_CYC, it is a normal completion using pslverr.
//  APB4_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for pready. TIMEOUT_CYC is unused.
// TESTING
//  1 Single read: req[0]=1, addr=12'h010, pready=1 in first ACCESS, prdata=32'hDEADBEEF
//    -> psel@1, penable@2, req_ack=2'b01@3, req_rdata=DEADBEEF, req_err=0.
//  2 Write strobes: req[1] write addr=12'h0A4, wdata=32'h12345678, strb=4'b0011, pready after 3 wait cycles
//    -> bus stable for 4 ACCESS cycles; pstrb=0011; req_ack=2'b10 one cycle after pready.
//    A read with strb=1111 drives pstrb=0000.
//  3 Round-robin: req=2'b11 held, each requester re-asserting after its ack
//    -> grant order 0,1,0,1; no requester gets two grants in a row; psel low 1 cycle between transfers.
//  4 Slave error: pslverr=1 with pready=1 -> req_err=1 with req_ack; the next transfer shows req_err=0.
//  5 Reset mid-ACCESS: assert preset during a pready=0 wait -> next edge all outputs 0, no req_ack.
//    Then req[1] alone is granted first cycle after reset release.
//  6 Timeout (APB4_TIMEOUT_EN, TIMEOUT_CYC=4): pready held 0 -> abort after 4 wait cycles, req_ack with
//    req_err=1, req_rdata=0. Without the macro the same stimulus stays in ACCESS for 1000 cycles.

Source files
------------

// File: rtl/apb4_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb4_req_arbiter
//   Shares one APB4 master port between NREQ local requesters. A round-robin
//   arbiter picks a pending request in IDLE. The block then runs the APB4
//   SETUP/ACCESS sequence and returns read data and error to the winner with
//   a one-cycle req_ack pulse.
//
//   Optional feature macro: APB4_TIMEOUT_EN
//     When defined, a transfer that waits TIMEOUT_CYC ACCESS cycles with
//     pready=0 is force-completed with req_err=1 and req_rdata=0.
//
// Ports
//   pclk, preset            clock, synchronous active-high reset
//   req/req_addr/req_write/ per-requester command; held until its req_ack
//   req_wdata/req_strb
//   req_ack                 one-hot completion pulse
//   req_rdata, req_err      completion data/error, valid with req_ack, held after
//   busy                    high while in SETUP or ACCESS
//   psel..pstrb             APB4 master outputs (pstrb forced to 0 on reads)
//   prdata/pready/pslverr   APB4 slave responses
// ----------------------------------------------------------------------------
module apb4_req_arbiter #(
    parameter int NREQ        = 2,
    parameter int ADDRWIDTH   = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*32-1:0]        req_wdata,
    input  logic [NREQ*4-1:0]         req_strb,
    output logic [NREQ-1:0]           req_ack,
    output logic [31:0]               req_rdata,
    output logic                      req_err,
    output logic                      busy,
    output logic                      psel,
    output logic [ADDRWIDTH-1:0]      paddr,
    output logic                      penable,
    output logic                      pwrite,
    output logic [31:0]               pwdata,
    output logic [3:0]                pstrb,
    input  logic [31:0]               prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [IDXW-1:0]      grant_q, grant_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic [NREQ-1:0]      req_ack_q, req_ack_d;
    logic [31:0]          req_rdata_q, req_rdata_d;
    logic                 req_err_q, req_err_d;

    logic                 timeout_hit;

`ifdef APB4_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
    logic [CNTW-1:0]      cnt_q, cnt_d;
    assign timeout_hit = (cnt_q == CNTW'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin pick: first eligible requester after ptr_q, wrapping.
    // A requester being acked this cycle is masked so it cannot win twice
    // back to back on a held req.
    logic [NREQ-1:0] elig;
    logic            found;
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] cand;

    assign elig = req & ~req_ack_q;

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (cand == IDXW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        req_ack_d   = '0;
        req_rdata_d = req_rdata_q;
        req_err_d   = req_err_q;
`ifdef APB4_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    ptr_d     = pick;
                    grant_d   = pick;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = req_addr[32'(pick)*ADDRWIDTH +: ADDRWIDTH];
                    pwrite_d  = req_write[pick];
                    pwdata_d  = req_wdata[32'(pick)*32 +: 32];
                    pstrb_d   = req_strb[32'(pick)*4 +: 4] & {4{req_write[pick]}};
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB4_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready || timeout_hit) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ST_IDLE;
                    req_ack_d = NREQ'(1) << grant_q;
                    // pready wins over a simultaneous timeout
                    if (pready) begin
                        req_rdata_d = pwrite_q ? '0 : prdata;
                        req_err_d   = pslverr;
                    end else begin
                        req_rdata_d = '0;
                        req_err_d   = 1'b1;
                    end
                end else begin
`ifdef APB4_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDXW'(NREQ - 1);
            grant_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            req_ack_q   <= '0;
            req_rdata_q <= '0;
            req_err_q   <= 1'b0;
`ifdef APB4_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            req_ack_q   <= req_ack_d;
            req_rdata_q <= req_rdata_d;
            req_err_q   <= req_err_d;
`ifdef APB4_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign req_ack   = req_ack_q;
    assign req_rdata = req_rdata_q;
    assign req_err   = req_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
